// File: rtl/flag_pkg.sv
// Shared types for the EX-stage flag unit: opcodes, condition codes, flag word and flag-class helpers.
package flag_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } ccc_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_Z    = 2'd1,
    FC_ZVN  = 2'd2
  } fclass_e;

  function automatic fclass_e flag_class(input logic [3:0] op);
    fclass_e fc;
    case (op)
      OP_ADD, OP_SUB:                 fc = FC_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z;
      default:                        fc = FC_NONE;
    endcase
    return fc;
  endfunction

  // Z-only classes keep the current V/N; Z always comes from the saturated result.
  function automatic flags_t next_flags(input fclass_e fc, input flags_t cur,
                                        input logic [15:0] res, input logic ovfl);
    flags_t r;
    r = cur;
    if (fc != FC_NONE) r.z = (res == 16'h0000);
    if (fc == FC_ZVN) begin
      r.v = ovfl;
      r.n = res[15];
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_flag_unit_cond_eval.sv
// Combinational branch-condition evaluator: condition code x flags -> taken.
module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] ccc,
  input  flags_t     f,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NEQ:    taken = ~f.z;
      CC_EQ:     taken = f.z;
      CC_GT:     taken = ~f.z & ~f.n;
      CC_LT:     taken = f.n;
      CC_GTE:    taken = f.z | (~f.z & ~f.n);
      CC_LTE:    taken = f.n | f.z;
      CC_OVFL:   taken = f.v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_unit.sv
// EX-stage Z/V/N flag register and branch resolver.
// Build option FLAG_BYPASS_EN: branches see in-flight flags instead of stalling.
module ex_flag_unit
  import flag_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        br_valid,
  input  logic [2:0]  br_ccc,
  output logic [2:0]  flags,
  output logic        br_taken,
  output logic        flag_stall
);

  fclass_e fc;
  logic    flag_we;
  flags_t  flags_q;
  flags_t  flags_nxt;
  flags_t  eval_flags;
  logic    cond_taken;
  logic    stall_int;

  assign fc        = flag_class(ex_opcode);
  assign flag_we   = ex_valid & ~ex_flush & (fc != FC_NONE);
  assign flags_nxt = next_flags(fc, flags_q, alu_result, alu_ovfl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       flags_q <= '0;
    else if (flag_we) flags_q <= flags_nxt;
  end

`ifdef FLAG_BYPASS_EN
  assign eval_flags = flag_we ? flags_nxt : flags_q;
  assign stall_int  = 1'b0;
`else
  assign eval_flags = flags_q;
  // Unconditional branches never read flags, so they never wait on a write.
  assign stall_int  = flag_we & br_valid & (br_ccc != CC_UNCOND);
`endif

  cond_eval u_cond_eval (
    .ccc   (br_ccc),
    .f     (eval_flags),
    .taken (cond_taken)
  );

  assign flags      = flags_q;
  assign flag_stall = rst_n & stall_int;
  assign br_taken   = rst_n & br_valid & cond_taken & ~stall_int;

endmodule
